// File: rtl/pll_pkg.sv
// Shared definitions for the divider bank: lock FSM encoding, DRP map constants, field positions.
// Also holds the clamp helpers applied when shadow configuration is committed.
package pll_pkg;

    typedef enum logic [1:0] {
        ST_OFF     = 2'b00,
        ST_LOCKING = 2'b01,
        ST_LOCKED  = 2'b10
    } pll_state_t;

    localparam logic [6:0] ADDR_STATUS = 7'h7E;
    localparam logic [6:0] ADDR_COMMIT = 7'h7F;

    localparam int FIELD_W         = 8;
    localparam int HIGH_LSB        = 0;
    localparam int PHASE_LSB       = 8;
    localparam int COMMIT_BIT      = 0;
    localparam int STAT_LOCKED_BIT = 0;
    localparam int STAT_STATE_LSB  = 1;

    function automatic logic [7:0] clamp_divide(input logic [7:0] d);
        return (d < 8'd2) ? 8'd2 : d;
    endfunction

    // d must already be clamped to >= 2 so that d-1 is a legal high time
    function automatic logic [7:0] clamp_high(input logic [7:0] h, input logic [7:0] d);
        if (h == 8'd0) return 8'd1;
        if (h > d - 8'd1) return d - 8'd1;
        return h;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divided-clock channel: phase hold, then a 0..divide-1 counter driving a registered output.
// Output is one cycle behind the counter; restart zeroes the counter and reloads the phase delay.
module clk_div_channel #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic                 restart,
    input  logic [CNT_WIDTH-1:0] divide,
    input  logic [CNT_WIDTH-1:0] high,
    input  logic [CNT_WIDTH-1:0] phase,
    output logic                 clkout
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] phase_cnt;

    always_ff @(posedge clk) begin
        if (rst || hold) begin
            count     <= '0;
            phase_cnt <= '0;
            clkout    <= 1'b0;
        end else if (restart) begin
            count     <= '0;
            phase_cnt <= phase;
            clkout    <= 1'b0;
        end else if (phase_cnt != '0) begin
            phase_cnt <= phase_cnt - CNT_ONE;
            clkout    <= 1'b0;
        end else begin
            clkout <= (count < high);
            count  <= (count == divide - CNT_ONE) ? '0 : count + CNT_ONE;
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of phase-aligned clock dividers with DRP shadow/commit configuration and a lock FSM.
// DRP completes one cycle after DEN (no stalls); LOCKED rises LOCK_CYCLES cycles after a restart.
module clk_div_bank
    import pll_pkg::*;
#(
    parameter int CHANNELS    = 6,
    parameter int CNT_WIDTH   = 8,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                CLKIN1,
    input  logic                RST,
    input  logic                PWRDWN,
    input  logic [6:0]          DADDR,
    input  logic                DEN,
    input  logic                DWE,
    input  logic [15:0]         DI,
    output logic [15:0]         DO,
    output logic                DRDY,
    output logic [CHANNELS-1:0] CLKOUT,
    output logic                LOCKED
);

    localparam logic [15:0]          LOCK_LAST = 16'(LOCK_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DIV_RST   = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0] HIGH_RST  = CNT_WIDTH'(1);

    pll_state_t state;
    pll_state_t state_nxt;
    logic [15:0] lock_cnt;
    logic        wr;
    logic        commit;
    logic        restart;
    logic [15:0] rd_data;

    logic [CNT_WIDTH-1:0] sh_div    [CHANNELS];
    logic [7:0]           sh_high   [CHANNELS];
    logic [7:0]           sh_phase  [CHANNELS];
    logic [CNT_WIDTH-1:0] act_div   [CHANNELS];
    logic [CNT_WIDTH-1:0] act_high  [CHANNELS];
    logic [CNT_WIDTH-1:0] act_phase [CHANNELS];
    logic [CNT_WIDTH-1:0] nxt_div   [CHANNELS];
    logic [CNT_WIDTH-1:0] nxt_high  [CHANNELS];
    logic [CNT_WIDTH-1:0] nxt_phase [CHANNELS];

    assign wr      = DEN && DWE && !RST;
    assign commit  = wr && (DADDR == ADDR_COMMIT) && DI[COMMIT_BIT];
    // OFF with PWRDWN low only happens on reset release or power-down exit
    assign restart = !RST && !PWRDWN && (commit || state == ST_OFF);

    always_comb begin
        rd_data = '0;
        if (DADDR == ADDR_STATUS) begin
            rd_data[STAT_LOCKED_BIT]     = LOCKED;
            rd_data[STAT_STATE_LSB +: 2] = state;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (DADDR == 7'(2 * i)) begin
                rd_data[CNT_WIDTH-1:0] = sh_div[i];
            end
            if (DADDR == 7'(2 * i + 1)) begin
                rd_data[HIGH_LSB +: FIELD_W]  = sh_high[i];
                rd_data[PHASE_LSB +: FIELD_W] = sh_phase[i];
            end
        end
    end

    always_ff @(posedge CLKIN1) begin
        if (RST) begin
            DRDY <= 1'b0;
            DO   <= '0;
        end else begin
            DRDY <= DEN;
            DO   <= (DEN && !DWE) ? rd_data : '0;
        end
    end

    always_ff @(posedge CLKIN1) begin
        if (RST) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sh_div[i]   <= DIV_RST;
                sh_high[i]  <= 8'd1;
                sh_phase[i] <= 8'd0;
            end
        end else if (wr) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (DADDR == 7'(2 * i)) begin
                    sh_div[i] <= DI[CNT_WIDTH-1:0];
                end
                if (DADDR == 7'(2 * i + 1)) begin
                    sh_high[i]  <= DI[HIGH_LSB +: FIELD_W];
                    sh_phase[i] <= DI[PHASE_LSB +: FIELD_W];
                end
            end
        end
    end

    // Channels load from the post-commit view so a commit's new phase takes effect on its own restart edge
    always_comb begin
        logic [7:0] div8;
        div8 = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            nxt_div[i]   = act_div[i];
            nxt_high[i]  = act_high[i];
            nxt_phase[i] = act_phase[i];
            if (commit) begin
                div8         = clamp_divide(8'(sh_div[i]));
                nxt_div[i]   = CNT_WIDTH'(div8);
                nxt_high[i]  = CNT_WIDTH'(clamp_high(sh_high[i], div8));
                nxt_phase[i] = CNT_WIDTH'(sh_phase[i]);
            end
        end
    end

    always_ff @(posedge CLKIN1) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (RST) begin
                act_div[i]   <= DIV_RST;
                act_high[i]  <= HIGH_RST;
                act_phase[i] <= '0;
            end else begin
                act_div[i]   <= nxt_div[i];
                act_high[i]  <= nxt_high[i];
                act_phase[i] <= nxt_phase[i];
            end
        end
    end

    always_ff @(posedge CLKIN1) begin
        if (RST) begin
            state <= ST_OFF;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (PWRDWN) begin
            state_nxt = ST_OFF;
        end else if (restart) begin
            state_nxt = ST_LOCKING;
        end else if (state == ST_LOCKING && lock_cnt == LOCK_LAST) begin
            state_nxt = ST_LOCKED;
        end
    end

    always_comb begin
        LOCKED = (state == ST_LOCKED);
    end

    always_ff @(posedge CLKIN1) begin
        if (RST || restart) begin
            lock_cnt <= '0;
        end else if (state == ST_LOCKING && lock_cnt != LOCK_LAST) begin
            lock_cnt <= lock_cnt + 16'd1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        clk_div_channel #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_ch (
            .clk     (CLKIN1),
            .rst     (RST),
            .hold    (PWRDWN),
            .restart (restart),
            .divide  (nxt_div[g]),
            .high    (nxt_high[g]),
            .phase   (nxt_phase[g]),
            .clkout  (CLKOUT[g])
        );
    end

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 6, number of divided clock outputs (1..32).
REQ-002 SHALL have parameter CNT_WIDTH, default 8, divider/high-time/phase field width (2..8).
REQ-003 SHALL have parameter LOCK_CYCLES, default 16, CLKIN1 cycles from restart to LOCKED (1..65535).
REQ-004 SHALL have port CLKIN1  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port PWRDWN  input  1  power-down, active-high.
REQ-007 SHALL have ports DADDR input 7, DEN input 1, DWE input 1, DI input 16: DRP address, enable, write-enable, write data.
REQ-008 SHALL have ports DO output 16, DRDY output 1: DRP read data, one-cycle completion strobe.
REQ-009 SHALL have ports CLKOUT output CHANNELS (divided clocks) and LOCKED output 1.

Function
REQ-010 Register map SHALL be: addr 2i = channel i DIVIDE (DI[CNT_WIDTH-1:0]); addr 2i+1 = channel i HIGH (DI[7:0]) and PHASE (DI[15:8]); 0x7E = status (read-only); 0x7F = COMMIT (write DI[0]=1).
REQ-011 Channel writes SHALL update shadow registers only; active configuration changes only on COMMIT.
REQ-012 DRP access SHALL be accepted in any cycle with DEN=1; DRDY SHALL be high exactly one cycle, the cycle after DEN; back-to-back DEN SHALL each get one DRDY.
REQ-013 Read DO SHALL return shadow value (unused bits 0) in the DRDY cycle and be 0 otherwise; status read SHALL return DO[0]=LOCKED, DO[2:1]=FSM state.
REQ-014 Unmapped address: read returns 0, write ignored, DRDY still asserted.
REQ-015 On COMMIT, active := shadow with clamps: DIVIDE<2 -> 2; HIGH clamped to [1, DIVIDE-1]; PHASE fields above CNT_WIDTH bits truncated.
REQ-016 Restart edge (reset release, COMMIT, PWRDWN fall) SHALL zero all channel counters simultaneously and load phase counters.
REQ-017 Channel i SHALL hold CLKOUT[i]=0 for PHASE_i cycles, then run counter 0..DIVIDE_i-1 wrapping; CLKOUT[i] registered, high while counter<HIGH_i.
REQ-018 With PHASE=0 CLKOUT[i] SHALL first rise 1 cycle after the restart edge; period DIVIDE_i, high time HIGH_i cycles.
REQ-019 FSM states SHALL be OFF(00), LOCKING(01), LOCKED(10); LOCKING->LOCKED after LOCK_CYCLES cycles; any restart -> LOCKING; PWRDWN=1 -> OFF from any state.
REQ-020 LOCKED SHALL be 1 only in state LOCKED; rises exactly LOCK_CYCLES cycles after the restart edge.
REQ-021 COMMIT during LOCKING SHALL restart the lock count.
REQ-022 In OFF: CLKOUT=0, LOCKED=0, DRP fully functional; COMMIT copies shadows but restart deferred to PWRDWN fall.
REQ-023 Simultaneous COMMIT and PWRDWN=1: PWRDWN wins state, shadows still copied.

Reset
REQ-024 RST=1 SHALL override DRP and PWRDWN in the same cycle.
REQ-025 Reset values: CLKOUT=0, LOCKED=0, DRDY=0, DO=0, state OFF; shadow and active DIVIDE=2, HIGH=1, PHASE=0.
REQ-026 First cycle after RST falls SHALL be a restart edge (state LOCKING if PWRDWN=0, else OFF).
REQ-027 A DRP access with DEN in a reset cycle SHALL be dropped (no DRDY).

Structure
REQ-028 Shared package pll_pkg SHALL hold FSM state encoding, DRP address constants (STATUS=0x7E, COMMIT=0x7F) and field bit positions.
REQ-029 Per-channel counter/phase/output logic SHALL be sub-module clk_div_channel, instantiated CHANNELS times by generate.

Verification
REQ-030 Reset release, PWRDWN=0, defaults -> all CLKOUT toggle 1,0 (period 2) from cycle 1; LOCKED=1 at cycle 16.
REQ-031 Write ch0 DIVIDE=4, HIGH=2/PHASE=0, ch1 DIVIDE=4, HIGH=1/PHASE=3, COMMIT -> ch0 pattern 1100, ch1 000 then 1000 repeating; LOCKED low 16 cycles.
REQ-032 Write DIVIDE=0, HIGH=9, COMMIT; read back -> DO=0 and 9 (shadow), output period 2 high 1.
REQ-033 COMMIT at cycle 10 of LOCKING -> LOCKED rises 16 cycles after second COMMIT, not the first.
REQ-034 PWRDWN=1 mid-run -> CLKOUT=0, LOCKED=0, status DO[2:1]=00; PWRDWN=0 -> restart, LOCKED after 16.
REQ-035 DEN on consecutive cycles to 0x00, 0x55, 0x7E -> three single-cycle DRDY; DO = 2, 0, {LOCKED,state}.
